// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue block, its register file and the ALU:
// data/instruction widths, instruction field positions, opcode values,
// flag-bit indices, the issue FSM state type and small opcode decode helpers.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned INSTR_W  = 24;
   localparam int unsigned OPC_W    = 8;
   localparam int unsigned REG_AW   = 2;
   localparam int unsigned NUM_REGS = 4;
   localparam int unsigned FLAG_W   = 5;

   // Instruction field positions
   localparam int unsigned OPC_MSB = 23;
   localparam int unsigned OPC_LSB = 16;
   localparam int unsigned RD_MSB  = 15;
   localparam int unsigned RD_LSB  = 14;
   localparam int unsigned RS1_MSB = 13;
   localparam int unsigned RS1_LSB = 12;
   localparam int unsigned RS2_MSB = 11;
   localparam int unsigned RS2_LSB = 10;
   localparam int unsigned UNU_MSB = 9;
   localparam int unsigned UNU_LSB = 8;
   localparam int unsigned IMM_MSB = 7;
   localparam int unsigned IMM_LSB = 0;

   // Opcodes
   localparam logic [OPC_W-1:0] OP_ADD  = 8'h00;
   localparam logic [OPC_W-1:0] OP_SUB  = 8'h01;
   localparam logic [OPC_W-1:0] OP_EQ   = 8'h03;
   localparam logic [OPC_W-1:0] OP_GT   = 8'h04;
   localparam logic [OPC_W-1:0] OP_ADDI = 8'h09;
   localparam logic [OPC_W-1:0] OP_SUBI = 8'h0A;
   localparam logic [OPC_W-1:0] OP_MOV  = 8'h0B;

   // Flag register bit indices: {overflow, carry, zero, sign, parity}
   localparam int unsigned FLAG_V = 4;
   localparam int unsigned FLAG_C = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_S = 1;
   localparam int unsigned FLAG_P = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_RETIRE = 2'd2
   } state_e;

   // Which flags an opcode updates when it retires
   typedef enum logic [1:0] {
      FUPD_NONE = 2'd0,
      FUPD_ALL  = 2'd1,
      FUPD_ZS   = 2'd2
   } flag_upd_e;

   function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_EQ, OP_GT, OP_ADDI, OP_SUBI, OP_MOV: return 1'b1;
         default:                                                return 1'b0;
      endcase
   endfunction

   function automatic logic op_uses_imm(input logic [OPC_W-1:0] op);
      return (op == OP_ADDI) || (op == OP_SUBI);
   endfunction

   function automatic flag_upd_e op_flag_upd(input logic [OPC_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: return FUPD_ALL;
         OP_EQ, OP_GT:                     return FUPD_ZS;
         default:                          return FUPD_NONE;
      endcase
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// Four 8-bit registers, R0 hard-wired to zero (writes to it are dropped).
// One synchronous write port, two combinational operand read ports and one
// combinational debug read port.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   we_i/waddr_i/wdata_i   write port
//   raddr1_i -> rdata1_o   operand read port 1
//   raddr2_i -> rdata2_o   operand read port 2
//   dbg_addr_i -> dbg_data_o  debug read port
// ---------------------------------------------------------------------------
module alu_regfile
   import alu_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] raddr1_i,
   output logic [DATA_W-1:0] rdata1_o,
   input  logic [REG_AW-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata2_o,
   input  logic [REG_AW-1:0] dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o
);

   localparam int unsigned NUM_RD = 3;

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   // Entry 0 is only ever cleared, so reading it always yields zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (we_i && (int'(waddr_i) == i)) begin
               regs_q[i] <= wdata_i;
            end
         end
      end
   end

   logic [NUM_RD-1:0][REG_AW-1:0] rd_addr;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

   assign rd_addr = {dbg_addr_i, raddr2_i, raddr1_i};

   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         assign rd_data[gi] = regs_q[rd_addr[gi]];
      end
   endgenerate

   assign rdata1_o   = rd_data[0];
   assign rdata2_o   = rd_data[1];
   assign dbg_data_o = rd_data[2];

endmodule

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
// Serialised issue/retire controller for an external combinational ALU.
// Each instruction takes three cycles: accept (IDLE), ALU active (ISSUE),
// result presented (RETIRE).
//   clk_in, reset_n_in           clock, asynchronous active-low reset
//   instr_valid_in/instr_in      instruction offer; instr_ready_out in IDLE
//   alu_reset_out/alu_enable_out ALU control
//   alu_opcode_out, alu_input1/2_out  registered ALU operation and operands
//   alu_result_in, alu_*_in      combinational ALU result and flags
//   result_valid/data/rd_out     retire pulse, written value and destination
//   flags_out                    {V, C, Z, S, P} flag register
//   illegal_out                  sticky illegal-opcode indicator
//   dbg_addr_in -> dbg_data_out  combinational register-file peek
// ---------------------------------------------------------------------------
module alu_issue
   import alu_pkg::*;
(
   input  logic                     clk_in,
   input  logic                     reset_n_in,
   input  logic                     instr_valid_in,
   input  logic [INSTR_W-1:0]       instr_in,
   output logic                     instr_ready_out,
   output logic                     alu_reset_out,
   output logic                     alu_enable_out,
   output logic [OPC_W-1:0]         alu_opcode_out,
   output logic signed [DATA_W-1:0] alu_input1_out,
   output logic signed [DATA_W-1:0] alu_input2_out,
   input  logic signed [DATA_W-1:0] alu_result_in,
   input  logic                     alu_overflow_in,
   input  logic                     alu_carry_in,
   input  logic                     alu_zero_in,
   input  logic                     alu_sign_in,
   input  logic                     alu_parity_in,
   output logic                     result_valid_out,
   output logic [DATA_W-1:0]        result_data_out,
   output logic [REG_AW-1:0]        result_rd_out,
   output logic [FLAG_W-1:0]        flags_out,
   output logic                     illegal_out,
   input  logic [REG_AW-1:0]        dbg_addr_in,
   output logic [DATA_W-1:0]        dbg_data_out
);

   state_e            state_q, state_d;
   logic [OPC_W-1:0]  opcode_q;
   logic [REG_AW-1:0] rd_q;
   logic [DATA_W-1:0] in1_q, in2_q;
   logic              legal_q;
   logic              illegal_q;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              res_valid_q;
   logic [DATA_W-1:0] res_data_q;
   logic [REG_AW-1:0] res_rd_q;
   logic              rst_s0_q, rst_s1_q;

   logic              transfer;
   logic              retire;
   logic              rf_we;
   logic [DATA_W-1:0] rs1_data, rs2_data;
   logic [FLAG_W-1:0] alu_flags;

   logic [OPC_W-1:0]  f_opc;
   logic [REG_AW-1:0] f_rd, f_rs1, f_rs2;
   logic [DATA_W-1:0] f_imm;
   logic              unused_bits;

   assign f_opc       = instr_in[OPC_MSB:OPC_LSB];
   assign f_rd        = instr_in[RD_MSB:RD_LSB];
   assign f_rs1       = instr_in[RS1_MSB:RS1_LSB];
   assign f_rs2       = instr_in[RS2_MSB:RS2_LSB];
   assign f_imm       = instr_in[IMM_MSB:IMM_LSB];
   assign unused_bits = ^instr_in[UNU_MSB:UNU_LSB];

   // ALU reset stretch: held high in reset and for one full cycle after
   // release, so the first accept happens two edges after release.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         rst_s0_q <= 1'b1;
         rst_s1_q <= 1'b1;
      end else begin
         rst_s0_q <= 1'b0;
         rst_s1_q <= rst_s0_q;
      end
   end

   assign alu_reset_out = rst_s1_q;

   // FSM state register
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and control outputs
   always_comb begin
      state_d         = state_q;
      instr_ready_out = 1'b0;
      alu_enable_out  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            instr_ready_out = ~rst_s1_q;
            if (instr_valid_in && !rst_s1_q) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            alu_enable_out = legal_q;
            state_d        = ST_RETIRE;
         end
         ST_RETIRE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign transfer = instr_valid_in & instr_ready_out;
   assign retire   = (state_q == ST_ISSUE);
   assign rf_we    = retire & legal_q;

   alu_regfile u_regfile (
      .clk_i      (clk_in),
      .rst_ni     (reset_n_in),
      .we_i       (rf_we),
      .waddr_i    (rd_q),
      .wdata_i    (alu_result_in),
      .raddr1_i   (f_rs1),
      .rdata1_o   (rs1_data),
      .raddr2_i   (f_rs2),
      .rdata2_o   (rs2_data),
      .dbg_addr_i (dbg_addr_in),
      .dbg_data_o (dbg_data_out)
   );

   assign alu_flags = {alu_overflow_in, alu_carry_in, alu_zero_in,
                       alu_sign_in, alu_parity_in};

   // Compare ops only touch Z/S; V, C and P keep their previous values.
   always_comb begin
      flags_d = flags_q;
      if (rf_we) begin
         case (op_flag_upd(opcode_q))
            FUPD_ALL: flags_d = alu_flags;
            FUPD_ZS: begin
               flags_d[FLAG_Z] = alu_zero_in;
               flags_d[FLAG_S] = alu_sign_in;
            end
            default: flags_d = flags_q;
         endcase
      end
   end

   // Instruction capture and retire datapath
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         opcode_q    <= '0;
         rd_q        <= '0;
         in1_q       <= '0;
         in2_q       <= '0;
         legal_q     <= 1'b0;
         illegal_q   <= 1'b0;
         flags_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_rd_q    <= '0;
      end else begin
         if (transfer) begin
            opcode_q <= f_opc;
            rd_q     <= f_rd;
            in1_q    <= rs1_data;
            in2_q    <= op_uses_imm(f_opc) ? f_imm : rs2_data;
            legal_q  <= op_is_legal(f_opc);
            if (!op_is_legal(f_opc)) begin
               illegal_q <= 1'b1;
            end
         end
         flags_q     <= flags_d;
         res_valid_q <= rf_we;
         if (rf_we) begin
            res_data_q <= alu_result_in;
            res_rd_q   <= rd_q;
         end
      end
   end

   assign alu_opcode_out   = opcode_q;
   assign alu_input1_out   = $signed(in1_q);
   assign alu_input2_out   = $signed(in2_q);
   assign result_valid_out = res_valid_q;
   assign result_data_out  = res_data_q;
   assign result_rd_out    = res_rd_q;
   assign flags_out        = flags_q;
   assign illegal_out      = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
// Directed bench for alu_issue with a small combinational ALU model attached
// to the ALU ports. Expected values are hand-computed per vector.
// ---------------------------------------------------------------------------
module tb_alu_issue;
   import alu_pkg::*;

   logic              clk_in = 1'b0;
   logic              reset_n_in;
   logic              instr_valid_in;
   logic [23:0]       instr_in;
   logic              instr_ready_out;
   logic              alu_reset_out;
   logic              alu_enable_out;
   logic [7:0]        alu_opcode_out;
   logic signed [7:0] alu_input1_out;
   logic signed [7:0] alu_input2_out;
   logic signed [7:0] alu_result_in;
   logic              alu_overflow_in, alu_carry_in, alu_zero_in;
   logic              alu_sign_in, alu_parity_in;
   logic              result_valid_out;
   logic [7:0]        result_data_out;
   logic [1:0]        result_rd_out;
   logic [4:0]        flags_out;
   logic              illegal_out;
   logic [1:0]        dbg_addr_in;
   logic [7:0]        dbg_data_out;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk_in = ~clk_in;

   alu_issue dut (
      .clk_in           (clk_in),
      .reset_n_in       (reset_n_in),
      .instr_valid_in   (instr_valid_in),
      .instr_in         (instr_in),
      .instr_ready_out  (instr_ready_out),
      .alu_reset_out    (alu_reset_out),
      .alu_enable_out   (alu_enable_out),
      .alu_opcode_out   (alu_opcode_out),
      .alu_input1_out   (alu_input1_out),
      .alu_input2_out   (alu_input2_out),
      .alu_result_in    (alu_result_in),
      .alu_overflow_in  (alu_overflow_in),
      .alu_carry_in     (alu_carry_in),
      .alu_zero_in      (alu_zero_in),
      .alu_sign_in      (alu_sign_in),
      .alu_parity_in    (alu_parity_in),
      .result_valid_out (result_valid_out),
      .result_data_out  (result_data_out),
      .result_rd_out    (result_rd_out),
      .flags_out        (flags_out),
      .illegal_out      (illegal_out),
      .dbg_addr_in      (dbg_addr_in),
      .dbg_data_out     (dbg_data_out)
   );

   // Environment ALU: carry is the unsigned carry/borrow out, MOV passes input1.
   logic [7:0] a_u, b_u, r_u;
   logic [8:0] t9;
   always_comb begin
      a_u = alu_input1_out;
      b_u = alu_input2_out;
      t9  = '0;
      r_u = '0;
      alu_overflow_in = 1'b0;
      alu_carry_in    = 1'b0;
      case (alu_opcode_out)
         8'h00, 8'h09: begin
            t9 = {1'b0, a_u} + {1'b0, b_u};
            r_u = t9[7:0];
            alu_carry_in    = t9[8];
            alu_overflow_in = (a_u[7] == b_u[7]) && (r_u[7] != a_u[7]);
         end
         8'h01, 8'h0A: begin
            t9 = {1'b0, a_u} - {1'b0, b_u};
            r_u = t9[7:0];
            alu_carry_in    = t9[8];
            alu_overflow_in = (a_u[7] != b_u[7]) && (r_u[7] != a_u[7]);
         end
         8'h03:   r_u = (a_u == b_u) ? 8'h01 : 8'h00;
         8'h04:   r_u = ($signed(a_u) > $signed(b_u)) ? 8'h01 : 8'h00;
         8'h0B:   r_u = a_u;
         default: r_u = 8'h00;
      endcase
      alu_result_in = $signed(r_u);
      alu_zero_in   = (r_u == 8'h00);
      alu_sign_in   = r_u[7];
      alu_parity_in = ^r_u;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reg(input logic [1:0] addr, input logic [7:0] exp);
      dbg_addr_in = addr;
      #1;
      check_eq($sformatf("R%0d", addr), dbg_data_out, exp);
   endtask

   // Issue one instruction and check it through ISSUE and RETIRE.
   // With hold_junk set, valid stays high with another instruction during
   // ISSUE; that instruction must not be consumed.
   task automatic exec(input logic [7:0] opc, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] imm, input logic legal,
                       input logic [7:0] exp_data, input logic [4:0] exp_flags,
                       input logic exp_illegal, input logic hold_junk);
      int n = 0;
      while (!instr_ready_out && n < 20) begin
         @(negedge clk_in);
         n++;
      end
      check_eq("ready_before_accept", instr_ready_out, 1'b1);
      instr_valid_in = 1'b1;
      instr_in = {opc, rd, rs1, rs2, 2'b00, imm};
      @(negedge clk_in);                      // ISSUE
      if (hold_junk) instr_in = {8'h09, 2'd3, 2'd0, 2'd0, 2'b00, 8'hAA};
      else instr_valid_in = 1'b0;
      check_eq("issue_enable", alu_enable_out, legal);
      check_eq("issue_ready_low", instr_ready_out, 1'b0);
      check_eq("issue_opcode", alu_opcode_out, opc);
      @(negedge clk_in);                      // RETIRE
      instr_valid_in = 1'b0;
      check_eq("retire_valid", result_valid_out, legal);
      if (legal) begin
         check_eq("retire_data", result_data_out, exp_data);
         check_eq("retire_rd", result_rd_out, rd);
      end
      check_eq("retire_enable_low", alu_enable_out, 1'b0);
      check_eq("flags", flags_out, exp_flags);
      check_eq("illegal", illegal_out, exp_illegal);
      @(negedge clk_in);                      // back in IDLE
      check_eq("idle_valid_low", result_valid_out, 1'b0);
      check_eq("idle_ready", instr_ready_out, 1'b1);
      $display("[TB] op=%02h rd=%0d rs1=%0d rs2=%0d imm=%02h -> valid=%0b data=%02h flags=%05b illegal=%0b",
               opc, rd, rs1, rs2, imm, legal, result_data_out, flags_out, illegal_out);
   endtask

   initial begin
      reset_n_in     = 1'b0;
      instr_valid_in = 1'b0;
      instr_in       = '0;
      dbg_addr_in    = 2'd0;
      #12;
      check_eq("rst_ready", instr_ready_out, 1'b0);
      check_eq("rst_alu_reset", alu_reset_out, 1'b1);
      check_eq("rst_flags", flags_out, 5'b00000);
      check_eq("rst_illegal", illegal_out, 1'b0);
      check_eq("rst_valid", result_valid_out, 1'b0);
      check_eq("rst_enable", alu_enable_out, 1'b0);
      @(negedge clk_in);
      reset_n_in = 1'b1;
      @(negedge clk_in);
      check_eq("rel1_alu_reset", alu_reset_out, 1'b1);
      check_eq("rel1_ready", instr_ready_out, 1'b0);
      @(negedge clk_in);
      check_eq("rel2_alu_reset", alu_reset_out, 1'b0);
      check_eq("rel2_ready", instr_ready_out, 1'b1);

      //   opc    rd    rs1   rs2   imm    legal data   flags     ill  junk
      exec(8'h09, 2'd1, 2'd0, 2'd0, 8'h7F, 1'b1, 8'h7F, 5'b00001, 1'b0, 1'b0);
      check_reg(2'd1, 8'h7F);
      exec(8'h09, 2'd2, 2'd0, 2'd0, 8'h01, 1'b1, 8'h01, 5'b00001, 1'b0, 1'b0);
      check_reg(2'd2, 8'h01);
      exec(8'h00, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, 8'h80, 5'b10011, 1'b0, 1'b0);
      check_reg(2'd3, 8'h80);
      exec(8'h03, 2'd2, 2'd1, 2'd1, 8'h00, 1'b1, 8'h01, 5'b10001, 1'b0, 1'b0);
      check_reg(2'd2, 8'h01);
      exec(8'h02, 2'd1, 2'd1, 2'd1, 8'h00, 1'b0, 8'h00, 5'b10001, 1'b1, 1'b0);
      check_reg(2'd1, 8'h7F);
      exec(8'h0A, 2'd1, 2'd1, 2'd0, 8'h7F, 1'b1, 8'h00, 5'b00100, 1'b1, 1'b0);
      check_reg(2'd1, 8'h00);
      exec(8'h09, 2'd0, 2'd0, 2'd0, 8'h55, 1'b1, 8'h55, 5'b00000, 1'b1, 1'b1);
      check_reg(2'd0, 8'h00);
      check_reg(2'd3, 8'h80);
      exec(8'h04, 2'd1, 2'd3, 2'd2, 8'h00, 1'b1, 8'h00, 5'b00100, 1'b1, 1'b0);
      exec(8'h0B, 2'd1, 2'd3, 2'd0, 8'h00, 1'b1, 8'h80, 5'b00100, 1'b1, 1'b0);
      check_reg(2'd1, 8'h80);
      exec(8'h01, 2'd2, 2'd2, 2'd3, 8'h00, 1'b1, 8'h81, 5'b11010, 1'b1, 1'b0);
      check_reg(2'd2, 8'h81);

      // Reset while ADD R3,R1,R2 is in ISSUE: no retire, no pulse.
      instr_valid_in = 1'b1;
      instr_in = {8'h00, 2'd3, 2'd1, 2'd2, 2'b00, 8'h00};
      @(negedge clk_in);
      instr_valid_in = 1'b0;
      check_eq("mid_issue_enable", alu_enable_out, 1'b1);
      reset_n_in = 1'b0;
      #1;
      check_eq("mid_rst_enable", alu_enable_out, 1'b0);
      check_eq("mid_rst_opcode", alu_opcode_out, 8'h00);
      check_eq("mid_rst_in1", alu_input1_out, 8'h00);
      check_eq("mid_rst_flags", flags_out, 5'b00000);
      check_eq("mid_rst_illegal", illegal_out, 1'b0);
      check_eq("mid_rst_alu_reset", alu_reset_out, 1'b1);
      check_reg(2'd3, 8'h00);
      @(negedge clk_in);
      check_eq("mid_rst_valid", result_valid_out, 1'b0);
      reset_n_in = 1'b1;
      @(negedge clk_in);
      check_eq("post_rst1_valid", result_valid_out, 1'b0);
      check_eq("post_rst1_ready", instr_ready_out, 1'b0);
      check_reg(2'd3, 8'h00);
      @(negedge clk_in);
      check_eq("post_rst2_ready", instr_ready_out, 1'b1);
      check_eq("post_rst2_valid", result_valid_out, 1'b0);

      exec(8'h09, 2'd1, 2'd0, 2'd0, 8'h01, 1'b1, 8'h01, 5'b00001, 1'b0, 1'b0);
      check_reg(2'd1, 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
